// File: rtl/mul_share_arbiter.sv
//==============================================================================
// Module : mul_share_arbiter
// Brief  : Round-robin sequencer sharing one pipelined multiplier between
//          N_REQ requesters; tracks valid/ID alongside the multiplier pipeline.
// Rev    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module mul_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [6*N_REQ-1:0]    req_a,
    input  logic [11*N_REQ-1:0]   req_b,
    output logic                  mul_ce,
    output logic [5:0]            mul_din0,
    output logic [10:0]           mul_din1,
    input  logic [10:0]           mul_dout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [10:0]           rsp_p,
    output logic                  idle
);

    localparam int c_A_W = 6;
    localparam int c_B_W = 11;

    // Shadow pipeline mirroring the multiplier stages
    logic [MUL_LAT-1:0]   r_sh_valid;
    logic [ID_W-1:0]      r_sh_id [MUL_LAT];
    logic [ID_W-1:0]      r_last_grant;

    logic                 w_arb_en;
    logic [N_REQ-1:0]     w_req_elig;
    logic                 w_grant_any;
    logic [ID_W-1:0]      w_grant_id;
    logic [ID_W-1:0]      w_cand;
    logic [N_REQ-1:0]     w_grant_oh;
    logic [c_A_W-1:0]     w_din0;
    logic [c_B_W-1:0]     w_din1;
    logic                 w_rsp_valid;

    // Outputs are forced to their reset values while reset is held low
    assign w_rsp_valid = reset & r_sh_valid[MUL_LAT-1];
    assign rsp_valid   = w_rsp_valid;
    assign rsp_id      = reset ? r_sh_id[MUL_LAT-1] : '0;
    assign rsp_p       = mul_dout;
    assign idle        = !reset || (r_sh_valid == '0);

    assign mul_ce      = !(w_rsp_valid && !rsp_ready);
    assign w_arb_en    = reset & mul_ce;
    assign w_req_elig  = req_valid & {N_REQ{w_arb_en}};

    // Search starts one past the last granted requester and wraps
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        w_cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = ID_W'((int'(r_last_grant) + k) % N_REQ);
            if (!w_grant_any && w_req_elig[w_cand]) begin
                w_grant_any = 1'b1;
                w_grant_id  = w_cand;
            end
        end
    end

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_ready
            assign w_grant_oh[i] = w_grant_any && (w_grant_id == ID_W'(i));
        end
    endgenerate

    assign req_ready = w_grant_oh;

    always_comb begin
        w_din0 = '0;
        w_din1 = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_oh[i]) begin
                w_din0 = w_din0 | req_a[i*c_A_W +: c_A_W];
                w_din1 = w_din1 | req_b[i*c_B_W +: c_B_W];
            end
        end
    end

    assign mul_din0 = w_din0;
    assign mul_din1 = w_din1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sh_valid   <= '0;
            r_last_grant <= ID_W'(N_REQ - 1);
            for (int s = 0; s < MUL_LAT; s++) begin
                r_sh_id[s] <= '0;
            end
        end else begin
            if (mul_ce) begin
                r_sh_valid[0] <= w_grant_any;
                r_sh_id[0]    <= w_grant_id;
                for (int s = 1; s < MUL_LAT; s++) begin
                    r_sh_valid[s] <= r_sh_valid[s-1];
                    r_sh_id[s]    <= r_sh_id[s-1];
                end
            end
            if (w_grant_any) begin
                r_last_grant <= w_grant_id;
            end
        end
    end

endmodule

`default_nettype wire
